// File: rtl/oeo_recirc_buffer_pkg.sv
// oeo_recirc_buffer_pkg: shared packet/request types and network constants
// for the speculative-scheme OEO recirculation buffers.
package oeo_recirc_buffer_pkg;
    localparam int PORTS        = 8;
    localparam int TOF          = 4;
    localparam int PORT_W       = $clog2(PORTS);
    localparam int DATA_W       = 64;
    localparam int BUF_FLAG_BIT = 32;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } packet_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] src;
        logic [PORT_W-1:0] dest;
    } req_t;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_state_e;
endpackage

// File: rtl/oeo_recirc_buffer_pkt_fifo.sv
// pkt_fifo: packet storage ring with wrap-around pointers and an occupancy
// count; the caller guarantees push never overflows and pop never underflows.
module pkt_fifo
    import oeo_recirc_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  packet_t       wdata,
    output packet_t       head,
    output logic [AW:0]   occupancy
);
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;
    packet_t       r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop) r_rptr <= r_rptr + 1'b1;
            r_occ <= r_occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= wdata;
    end

    assign head      = r_mem[r_rptr];
    assign occupancy = r_occ;
endmodule

// File: rtl/oeo_recirc_buffer.sv
// oeo_recirc_buffer: per-port electronic recirculation buffer; stores packets
// diverted by the switch and re-injects the FIFO head once the scheduler grants it.
module oeo_recirc_buffer
    import oeo_recirc_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PORT_ID = 0,
    parameter int CNT_W   = 16,
    localparam int OW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  packet_t          din,
    input  logic             grant_in,
    output req_t             req_out,
    output packet_t          dout,
    output logic             full,
    output logic [OW-1:0]    occupancy,
    output logic [CNT_W-1:0] drop_cnt
);
    occ_state_e       r_state;
    logic             r_full;
    logic [CNT_W-1:0] r_drop;
    packet_t          r_dout;
    packet_t          w_head;
    logic [OW-1:0]    w_occ;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // A pop frees a slot this cycle, so a full buffer can still accept a write.
    assign w_pop  = grant_in & (w_occ != '0);
    assign w_push = din.valid & (!r_full | w_pop);
    assign w_drop = din.valid & r_full & !w_pop;

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (din),
        .head      (w_head),
        .occupancy (w_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCC_EMPTY;
            r_full  <= 1'b0;
            r_drop  <= '0;
            r_dout  <= '0;
        end else begin
            r_dout <= w_pop ? w_head : '0;
            if (w_drop && r_drop != {CNT_W{1'b1}}) r_drop <= r_drop + 1'b1;
            case (r_state)
                OCC_EMPTY: if (w_push) r_state <= OCC_PARTIAL;
                OCC_PARTIAL: begin
                    if (w_push && !w_pop && w_occ == OW'(DEPTH - 1)) begin
                        r_state <= OCC_FULL;
                        r_full  <= 1'b1;
                    end else if (w_pop && !w_push && w_occ == OW'(1)) begin
                        r_state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_pop && !w_push) begin
                        r_state <= OCC_PARTIAL;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= OCC_EMPTY;
                    r_full  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_out       = '0;
        req_out.valid = w_occ != '0;
        req_out.src   = PORT_W'(PORT_ID);
        req_out.dest  = w_head.dest;
    end

    assign dout      = r_dout;
    assign full      = r_full;
    assign occupancy = w_occ;
    assign drop_cnt  = r_drop;
endmodule

// File: doc/oeo_recirc_buffer.md
Name: oeo_recirc_buffer

Overview:
- Per-port electronic (OEO) recirculation buffer for speculative network scheme 1.
- Consumes packets that the photonic switch diverts to its buffer port (dto_buf[k]) and stores them in FIFO order.
- Requests re-injection of the head packet from the scheduler and, once granted, returns it to the switch on dfrom_buf[k].
- One instance per switch port.

Parameters:
- DEPTH, 8, packet slots in the buffer; power of two, at least 2.
- PORT_ID, 0, index of the switch port this instance serves; drives req_out.src.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  packet_t  packet diverted to this buffer (dto_buf[PORT_ID]); accepted only when din.valid=1
- grant_in  in  1  scheduler grant for the current head packet
- req_out  out  req_t  re-injection request: valid, src=PORT_ID, dest=head.dest
- dout  out  packet_t  re-injected packet to the switch (dfrom_buf[PORT_ID])
- full  out  1  occupancy == DEPTH
- occupancy  out  $clog2(DEPTH)+1  packets currently stored
- drop_cnt  out  CNT_W  packets lost to overflow, saturating

Behaviour:
- Reset: asynchronous on rst_n low, taking effect immediately.
  - Clears read/write pointers and occupancy, and forces full=0 and drop_cnt=0.
  - Forces dout.valid=0 and dout to all-zero.
  - req_out.valid=0 while the buffer is empty.
  - Stored packets are lost; reset mid-transfer discards a pending pop.
- pop: pop = grant_in & req_out.valid.
  - grant_in while empty is ignored: no pop, no state change.
- Write: accepted when din.valid & (occupancy<DEPTH | pop).
  - Packet is stored unmodified; data[32] stays as set by the switch.
- Overflow: din.valid & full & !pop.
  - Packet is dropped and drop_cnt increments by 1, holding at 2^CNT_W-1.
  - occupancy and pointers are unchanged.
- Read latency:
  - Grant at edge N pops the head; dout carries that packet with valid=1 for exactly the cycle after edge N.
  - Without a pop, dout.valid=0 on the following cycle. dout is registered.
- req_out is combinational from registered state:
  - valid = (occupancy!=0); dest = head.dest; src = PORT_ID.
  - On the cycle after a pop it shows the next head.
- Simultaneous write and pop:
  - Occupancy unchanged, both pointers advance.
  - When empty, a write and a grant in the same cycle do not bypass: req_out.valid was 0, so no pop occurs; the packet is readable from the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full and empty derive from occupancy, not pointer equality.
- Occupancy control state: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY->PARTIAL on write.
  - PARTIAL->FULL on write without pop at DEPTH-1.
  - FULL->PARTIAL on pop without write.
  - PARTIAL->EMPTY on pop without write at 1.
  - All other combinations hold state.
- full is registered and equals (occupancy==DEPTH).
- Head-of-line order is strict FIFO; no reordering by destination.

Decomposition:
- config.sv (shared):
  - packet_t with fields valid, dest, data; data[32] is the buffered flag.
  - req_t with fields valid, src, dest.
  - Constants `PORTS and `TOF.
- Add a PORT_W constant (= $clog2(`PORTS)) to config.sv for dest/src widths.
- One sub-module: pkt_fifo.
  - Storage array plus pointers, parameterised by DEPTH, with push/pop/head/occupancy.
  - oeo_recirc_buffer wraps it with the request, grant and drop logic and the registered dout.

Test Plan:
- Reset with buffer holding 3 packets (rst_n low mid-cycle) -> immediately occupancy=0, req_out.valid=0, dout.valid=0, drop_cnt=0.
- Write packets dest=2,5,1 on cycles 0-2, no grant -> occupancy=3, req_out.dest=2; grant on cycle 4 -> dout.dest=2 valid only in cycle 5, req_out.dest=5 in cycle 5.
- Fill DEPTH=8, then write 2 more without grant -> full=1, occupancy=8, drop_cnt=2; a later grant sequence returns the original 8 in order.
- With full=1, din.valid and grant_in in the same cycle -> packet accepted, occupancy stays 8, drop_cnt unchanged, head advances.
- Empty buffer, din.valid and grant_in together -> no dout next cycle, occupancy=1, req_out.valid=1; grant on the following cycle -> dout.valid=1 one cycle later.
- Streaming: 20 writes with a grant every cycle after the first -> pointers wrap twice, all 20 emerge in order with 1-cycle grant-to-dout latency, drop_cnt=0.
